// File: rtl/div_pkg.sv
// Shared encodings and helpers for the iterative 32-bit divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_SIGNED           = 1'b1;
    localparam logic DIV_UNSIGNED         = 1'b0;

    localparam logic [5:0] DIV_LAST_CNT = 6'd32;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of an operand; only signed operands with bit 31 set are negated.
    function automatic logic [31:0] abs_op(input logic sgn, input logic [31:0] x);
        if (sgn && x[31]) begin
            return neg32(x);
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider (DIV/DIVU): one quotient bit per cycle,
// result {remainder, quotient} held with ready_o until EX drops start_i.
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_signed;
    logic        r_dvd_neg;
    logic        r_dvs_neg;
    logic        r_ready;
    logic [63:0] r_result;

    div_state_e  w_state_next;
    logic [5:0]  w_cnt_next;
    logic [64:0] w_work_next;
    logic [31:0] w_divisor_next;
    logic        w_signed_next;
    logic        w_dvd_neg_next;
    logic        w_dvs_neg_next;
    logic        w_ready_next;
    logic [63:0] w_result_next;

    logic [32:0] w_diff;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_diff = {1'b0, r_work[63:32]} - {1'b0, r_divisor};
    assign w_quo  = (r_signed && (r_dvd_neg ^ r_dvs_neg)) ? neg32(r_work[31:0]) : r_work[31:0];
    assign w_rem  = (r_signed && r_dvd_neg) ? neg32(r_work[64:33]) : r_work[64:33];

    // Next-state and next-register values for the whole divider.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_work_next    = r_work;
        w_divisor_next = r_divisor;
        w_signed_next  = r_signed;
        w_dvd_neg_next = r_dvd_neg;
        w_dvs_neg_next = r_dvs_neg;
        w_ready_next   = DIV_RESULT_NOT_READY;
        w_result_next  = 64'd0;
        case (r_state)
            DIV_FREE: begin
                if ((start_i == DIV_START) && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        w_state_next = DIV_BY_ZERO;
                    end else begin
                        w_state_next   = DIV_ON;
                        w_cnt_next     = 6'd0;
                        w_work_next    = {32'd0, abs_op(signed_div_i, opdata1_i), 1'b0};
                        w_divisor_next = abs_op(signed_div_i, opdata2_i);
                        w_signed_next  = signed_div_i;
                        w_dvd_neg_next = signed_div_i & opdata1_i[31];
                        w_dvs_neg_next = signed_div_i & opdata2_i[31];
                    end
                end else begin
                    w_state_next = DIV_FREE;
                end
            end
            DIV_BY_ZERO: begin
                w_state_next = DIV_END;
                w_work_next  = 65'd0;
            end
            DIV_ON: begin
                if (annul_i) begin
                    w_state_next = DIV_FREE;
                    w_cnt_next   = 6'd0;
                end else if (r_cnt == DIV_LAST_CNT) begin
                    // Final result is parked in the working register until DIV_END.
                    w_state_next = DIV_END;
                    w_cnt_next   = 6'd0;
                    w_work_next  = {1'b0, w_rem, w_quo};
                end else begin
                    w_cnt_next = r_cnt + 6'd1;
                    if (w_diff[32]) begin
                        w_work_next = {r_work[63:0], 1'b0};
                    end else begin
                        w_work_next = {w_diff[31:0], r_work[31:0], 1'b1};
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    w_state_next = DIV_FREE;
                end else begin
                    w_ready_next  = DIV_RESULT_READY;
                    w_result_next = r_work[63:0];
                end
            end
            default: begin
                w_state_next = DIV_FREE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_signed  <= 1'b0;
            r_dvd_neg <= 1'b0;
            r_dvs_neg <= 1'b0;
            r_ready   <= 1'b0;
            r_result  <= 64'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_work    <= w_work_next;
            r_divisor <= w_divisor_next;
            r_signed  <= w_signed_next;
            r_dvd_neg <= w_dvd_neg_next;
            r_dvs_neg <= w_dvs_neg_next;
            r_ready   <= w_ready_next;
            r_result  <= w_result_next;
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset inputs.
REQ-002 clk  input  1  Rising-edge clock shared with the pipeline.
REQ-003 rst  input  1  Asynchronous, active-high reset (`RstEnable`).
REQ-004 signed_div_i  input  1  1 = DIV (signed); 0 = DIVU (unsigned); sampled with start_i in DIV_FREE.
REQ-005 opdata1_i  input  32  Dividend; sampled with start_i in DIV_FREE.
REQ-006 opdata2_i  input  32  Divisor; sampled with start_i in DIV_FREE.
REQ-007 start_i  input  1  Division request from EX; held high by EX until it has consumed ready_o.
REQ-008 annul_i  input  1  Abort of the in-flight division (flush); effective in DIV_ON only.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}, written to HI/LO by EX.
REQ-010 ready_o  output  1  result_o valid; EX releases its stall on this.

Function
REQ-011 The FSM SHALL have states DIV_FREE, DIV_BY_ZERO, DIV_ON and DIV_END.
REQ-012 DIV_FREE, start_i=1, annul_i=0, opdata2_i=0: next state DIV_BY_ZERO.
REQ-013 DIV_FREE, start_i=1, annul_i=0, opdata2_i!=0: next state DIV_ON; latch |operands| (two's-complement negate when signed_div_i=1 and bit 31=1) and the operand signs; clear the iteration counter; set the 65-bit working register to {32'b0, |dividend|, 1'b0}.
REQ-014 DIV_FREE otherwise: hold state; ready_o=0, result_o=0.
REQ-015 DIV_BY_ZERO: next state DIV_END with result 64'h0.
REQ-016 DIV_ON, per cycle: one restoring step.
- Trial difference = working[63:32] − |divisor| (33-bit).
- Negative: shift working left 1, new bit 0 = 0.
- Non-negative: working = {difference[31:0], working[31:0], 1'b1}.
- Counter increments by 1.
REQ-017 DIV_ON, counter reaches 32 (after 32 steps):
- quotient = working[31:0]; remainder = working[64:33].
- If signed and dividend sign XOR divisor sign = 1: negate quotient.
- If signed and dividend negative: negate remainder.
- Next state DIV_END.
REQ-018 DIV_ON, annul_i=1: next state DIV_FREE, counter cleared, result discarded, regardless of counter value.
REQ-019 DIV_END: ready_o=1 and result_o stable; hold state while start_i=1; when start_i=0, next state DIV_FREE with ready_o=0 and result_o=0.
REQ-020 Latency: start_i sampled on edge N gives ready_o high after edge N+34 (nonzero divisor) or after edge N+2 (zero divisor).
REQ-021 Signed −2^31 / −1 SHALL yield quotient 32'h80000000 and remainder 0, with no exception.
REQ-022 Changes of opdata*_i or signed_div_i after the start edge SHALL NOT affect the result in progress.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst=1 SHALL asynchronously force: state DIV_FREE, counter 0, working register 0, result_o 64'h0, ready_o 0. This applies in any state, including mid-division.
REQ-025 After rst deasserts with start_i=1 held, a new division SHALL begin on the first following edge.

Structure
REQ-026 State codes (2 bits), DivResultReady/DivResultNotReady, DivStart/DivStop and signed/unsigned flags SHALL be added to the shared defines.v header.
REQ-027 The block SHALL be a single module with no sub-module; EX instantiates it as a sibling, and the top level connects EX start/annul/operands to it.

Verification
REQ-028 Unsigned 100 / 7, start held → ready_o after edge N+34, result_o = {32'd2, 32'd14}; start_i dropped → ready_o=0 next edge.
REQ-029 Signed −7 / 2 (32'hFFFFFFF9, 2) → quotient 32'hFFFFFFFD (−3), remainder 32'hFFFFFFFF (−1).
REQ-030 Signed 32'h80000000 / 32'hFFFFFFFF → {32'h0, 32'h80000000}; unsigned 32'hFFFFFFFF / 1 → {0, 32'hFFFFFFFF}.
REQ-031 Divide by zero, any dividend → ready_o after edge N+2, result_o = 0.
REQ-032 annul_i pulsed at counter 15 → DIV_FREE next edge, ready_o never asserted. A new start_i for 9/3 then gives {0, 3}.
REQ-033 rst asserted asynchronously (between edges) at counter 20 → outputs 0 immediately; a start held through reset release gives a correct result 34 edges later.
